// File: rtl/reg_intf_pkg.sv
// Shared definitions for the SPI-to-register-bus bridge.
//   Frame layout (MSB first): [31] RW (1=write), [30] reserved (must be 0),
//   [29:16] register address, [15:0] write data / don't-care on reads.
//   The *_POS constants index the rx shift register at the clk where the
//   final bit of a field group is still arriving on mosi (i.e. before that
//   last shift has landed).
package reg_intf_pkg;

  localparam int unsigned SPI_FRAME_W = 32;
  localparam int unsigned HDR_W       = 16;
  localparam int unsigned RW_BIT      = 31;
  localparam int unsigned RSVD_BIT    = 30;
  localparam int unsigned BIT_CNT_W   = 6;

  // Header bits as seen in rx_sr while the 16th bit is on mosi
  localparam int unsigned HDR_RW_POS   = RW_BIT - HDR_W - 1;
  localparam int unsigned HDR_RSVD_POS = RSVD_BIT - HDR_W - 1;
  // RW bit as seen in rx_sr while the 32nd bit is on mosi
  localparam int unsigned END_RW_POS   = RW_BIT - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_DATA,
    ST_WR,
    ST_DONE,
    ST_ERR
  } spi_br_state_t;

endpackage

// File: rtl/reg_bridge_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with optional
// rise/fall detection.
//   clk   : system clock
//   rst   : asynchronous active-low reset (chain clears to 0)
//   d     : asynchronous input
//   q     : synchronised level (last chain stage)
//   rise  : one-clk pulse when q goes 0->1 (0 when EDGE_DET=0)
//   fall  : one-clk pulse when q goes 1->0 (0 when EDGE_DET=0)
// The chain resets to 0 on every pin. For cs_n this means a host already
// holding cs_n low at reset release produces no fall event, so no partial
// frame can start until cs_n rises and falls again.
module reg_bridge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_DET    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

  generate
    if (EDGE_DET) begin : g_edge
      // Edge compare uses one extra flop behind q, so an edge pulse coincides
      // with the clk on which q shows the new level; a mosi chain of equal
      // depth then presents the bit the host set up for that sclk edge.
      logic q_d;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q_d <= 1'b0;
        end else begin
          q_d <= q;
        end
      end
      assign rise = q & ~q_d;
      assign fall = ~q & q_d;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/reg_spi_bridge.sv
// SPI mode-0 slave that converts 32-bit host frames into single-cycle
// register bus accesses; one access per valid frame, read data returned on
// miso in the second half of the same frame.
//   clk, rst          : system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi: async host pins (f_sclk <= f_clk/16)
//   spi_miso, _oe     : data to host (MSB first) and its output enable
//   wr_en, rd_en      : one-clk strobes to the register file
//   addr              : register address, held from header decode on
//   write_data        : write payload, valid with wr_en
//   read_data         : register file read mux (combinational in addr)
//   frame_err         : one-clk pulse on aborted or malformed frame
//   busy              : frame in progress
module reg_spi_bridge
  import reg_intf_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              frame_err,
  output logic              busy
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  spi_br_state_t            state;
  logic [BIT_CNT_W-1:0]     bit_cnt;
  logic [SPI_FRAME_W-1:0]   rx_sr;
  logic [DATA_W-1:0]        tx_sr;
  logic                     unused_rx_msb;

  reg_bridge_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (spi_sclk),
    .q (sclk_s), .rise (sclk_rise), .fall (sclk_fall)
  );

  reg_bridge_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_cs (
    .clk (clk), .rst (rst), .d (spi_cs_n),
    .q (cs_s), .rise (cs_rise), .fall (cs_fall)
  );

  reg_bridge_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_mosi (
    .clk (clk), .rst (rst), .d (spi_mosi),
    .q (mosi_s), .rise (unused_mosi_rise), .fall (unused_mosi_fall)
  );

  // Only edges of sclk/cs_n drive the FSM; the levels are kept for clarity.
  logic unused_levels;
  assign unused_levels = sclk_s ^ cs_s;
  // The frame MSB shifts out of rx_sr before anything needs it.
  assign unused_rx_msb = rx_sr[SPI_FRAME_W-1];

  // miso is the tx register MSB; clearing tx_sr forces miso low.
  assign spi_miso = tx_sr[DATA_W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      spi_miso_oe <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      addr        <= '0;
      write_data  <= '0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      frame_err <= 1'b0;

      if (cs_rise && (state != ST_IDLE)) begin
        // Completed (WR/DONE) or already-flagged (ERR) frames end quietly;
        // anything earlier is an abort.
        frame_err   <= (state != ST_WR) && (state != ST_DONE) && (state != ST_ERR);
        state       <= ST_IDLE;
        bit_cnt     <= '0;
        tx_sr       <= '0;
        spi_miso_oe <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_HDR;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end

          ST_HDR: begin
            if (sclk_rise) begin
              rx_sr   <= {rx_sr[SPI_FRAME_W-2:0], mosi_s};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_CNT_W'(HDR_W - 1)) begin
                if (rx_sr[HDR_RSVD_POS]) begin
                  state     <= ST_ERR;
                  frame_err <= 1'b1;
                end else begin
                  addr <= {rx_sr[ADDR_W-2:0], mosi_s};
                  if (rx_sr[HDR_RW_POS]) begin
                    state <= ST_DATA;
                  end else begin
                    state <= ST_RD_REQ;
                    rd_en <= 1'b1;
                  end
                end
              end
            end
          end

          // addr is registered and rd_en is high this clk, so read_data is
          // valid now; capturing it here puts bit 15 on miso in RD_CAP.
          ST_RD_REQ: begin
            tx_sr       <= read_data;
            spi_miso_oe <= 1'b1;
            state       <= ST_RD_CAP;
          end

          ST_RD_CAP: begin
            state <= ST_DATA;
          end

          ST_DATA: begin
            if (sclk_rise) begin
              rx_sr   <= {rx_sr[SPI_FRAME_W-2:0], mosi_s};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_CNT_W'(SPI_FRAME_W - 1)) begin
                if (rx_sr[END_RW_POS]) begin
                  state      <= ST_WR;
                  wr_en      <= 1'b1;
                  write_data <= {rx_sr[DATA_W-2:0], mosi_s};
                end else begin
                  state <= ST_DONE;
                end
              end
            end else if (sclk_fall && spi_miso_oe &&
                         (bit_cnt >= BIT_CNT_W'(HDR_W + 1))) begin
              // oe marks a read; the fall after rise 16 keeps bit 15 on miso.
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
          end

          ST_WR: begin
            state <= ST_DONE;
          end

          default: begin
            // DONE / ERR: wait for cs_n rise, ignore sclk
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_spi_bridge.sv
module tb_reg_spi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        wr_en, rd_en, frame_err, busy;
  logic [13:0] addr;
  logic [15:0] write_data, read_data;

  int vectors = 0;
  int miscompares = 0;

  // bus-side monitor / register file model
  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_cnt = 0, both_cnt = 0;
  logic [13:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;
  logic [15:0] mem [16];

  int w0, r0, e0, o0;
  logic [31:0] rx;

  always #5 clk = ~clk;

  reg_spi_bridge #(.SYNC_STAGES(2), .ADDR_W(14), .DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .write_data  (write_data),
    .read_data   (read_data),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  assign read_data = (addr == 14'h0040) ? 16'hBEEF : mem[addr[3:0]];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= addr;
      last_wr_data <= write_data;
      mem[addr[3:0]] <= write_data;
    end
    if (rd_en)         rd_cnt   <= rd_cnt + 1;
    if (frame_err)     err_cnt  <= err_cnt + 1;
    if (spi_miso_oe)   oe_cnt   <= oe_cnt + 1;
    if (wr_en && rd_en) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cnt;
  endtask

  // Mode-0 host: mosi set half a period before each rise, miso sampled at the rise.
  // sclk period 160 ns = 16 clk periods.
  task automatic spi_xfer(input logic [39:0] bits, input int n, input bit drop_cs,
                          output logic [31:0] rx_o);
    logic [31:0] r;
    r = '0;
    spi_cs_n = 1'b0;
    #80;
    for (int i = 0; i < n; i++) begin
      spi_mosi = bits[n-1-i];
      #80;
      r = {r[30:0], spi_miso};
      spi_sclk = 1'b1;
      #80;
      spi_sclk = 1'b0;
    end
    #80;
    if (drop_cs) begin
      spi_cs_n = 1'b1;
      #320;
    end
    rx_o = r;
  endtask

  initial begin
    rst = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    #52;
    chk("rst_miso",   {31'd0, spi_miso},    32'd0);
    chk("rst_oe",     {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_addr",   {18'd0, addr},        32'd0);
    chk("rst_wdata",  {16'd0, write_data},  32'd0);
    chk("rst_strobe", {29'd0, wr_en, rd_en, frame_err}, 32'd0);
    chk("rst_busy",   {31'd0, busy},        32'd0);
    rst = 1'b1;
    #100;

    // write 0x000C = 0x1234
    snap();
    spi_cs_n = 1'b0; #200;
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    spi_xfer(40'h00_800C_1234, 32, 1'b1, rx);
    chk("wr1_wr_cnt", wr_cnt - w0, 1);
    chk("wr1_rd_cnt", rd_cnt - r0, 0);
    chk("wr1_err",    err_cnt - e0, 0);
    chk("wr1_addr",   {18'd0, last_wr_addr}, 32'h000C);
    chk("wr1_data",   {16'd0, last_wr_data}, 32'h1234);
    chk("wr1_busy",   {31'd0, busy}, 32'd0);

    // read 0x0040 -> 0xBEEF
    snap();
    spi_xfer(40'h00_0040_0000, 32, 1'b1, rx);
    chk("rd1_rd_cnt", rd_cnt - r0, 1);
    chk("rd1_wr_cnt", wr_cnt - w0, 0);
    chk("rd1_err",    err_cnt - e0, 0);
    chk("rd1_addr",   {18'd0, addr}, 32'h0040);
    chk("rd1_miso",   rx, 32'h0000_BEEF);
    chk("rd1_oe_off", {31'd0, spi_miso_oe}, 32'd0);
    chk("rd1_miso_off", {31'd0, spi_miso}, 32'd0);

    // write aborted after 20 bits, then a good write
    snap();
    spi_xfer(40'h00_000_800C5, 20, 1'b1, rx);
    chk("abort_wr_cnt", wr_cnt - w0, 0);
    chk("abort_err",    err_cnt - e0, 1);
    chk("abort_busy",   {31'd0, busy}, 32'd0);
    snap();
    spi_xfer(40'h00_8003_5678, 32, 1'b1, rx);
    chk("post_abort_wr", wr_cnt - w0, 1);
    chk("post_abort_data", {16'd0, last_wr_data}, 32'h5678);
    chk("post_abort_err", err_cnt - e0, 0);

    // reserved bit set
    snap();
    spi_xfer(40'h00_C010_0000, 32, 1'b1, rx);
    chk("rsvd_err", err_cnt - e0, 1);
    chk("rsvd_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
    chk("rsvd_oe", oe_cnt - o0, 0);

    // 40-bit write frame: only the first 32 bits count
    snap();
    spi_xfer(40'h80_0599_99FF, 40, 1'b1, rx);
    chk("long_wr_cnt", wr_cnt - w0, 1);
    chk("long_addr",   {18'd0, last_wr_addr}, 32'h0005);
    chk("long_data",   {16'd0, last_wr_data}, 32'h9999);
    chk("long_err",    err_cnt - e0, 0);

    // reset in the data phase of a read, cs_n held low across release
    spi_xfer(40'h00_000_00400, 20, 1'b0, rx);
    rst = 1'b0;
    #1;
    chk("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("mid_rst_oe",   {31'd0, spi_miso_oe}, 32'd0);
    chk("mid_rst_addr", {18'd0, addr}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    #49;
    rst = 1'b1;
    #100;
    snap();
    spi_xfer(40'h00_800A_0F0F, 32, 1'b0, rx);
    chk("held_cs_access", (wr_cnt - w0) + (rd_cnt - r0) + (err_cnt - e0), 0);
    chk("held_cs_busy", {31'd0, busy}, 32'd0);
    spi_cs_n = 1'b1;
    #320;
    snap();
    spi_xfer(40'h00_800A_0F0F, 32, 1'b1, rx);
    chk("fresh_wr_cnt", wr_cnt - w0, 1);
    chk("fresh_addr",   {18'd0, last_wr_addr}, 32'h000A);
    chk("fresh_data",   {16'd0, last_wr_data}, 32'h0F0F);

    // back-to-back write then read-back with a 2-sclk-period gap
    snap();
    spi_xfer(40'h00_8002_A5A5, 32, 1'b1, rx);
    spi_xfer(40'h00_0002_0000, 32, 1'b1, rx);
    chk("b2b_wr_cnt", wr_cnt - w0, 1);
    chk("b2b_rd_cnt", rd_cnt - r0, 1);
    chk("b2b_readback", rx, 32'h0000_A5A5);
    chk("no_dual_strobe", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
